// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit.
//
// Holds the MIPS branch opcode values, the 2-bit predictor counter type,
// its saturation limits, and the saturating update helper.
// The predictor table and the top level both use these definitions.

package branch_pkg;

    // Opcode field values of the five conditional branches
    localparam logic [5:0] OP_BLTZ = 6'd1;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_BLEZ = 6'd6;
    localparam logic [5:0] OP_BGTZ = 6'd7;

    // 2-bit saturating predictor counter; bit 1 is the taken prediction
    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_MAX = 2'd3;
    localparam cnt_t CNT_MIN = 2'd0;

    // Moves a counter one step towards taken or not-taken, clamping at the ends
    function automatic cnt_t cnt_update(input cnt_t cnt, input logic up);
        cnt_t nxt;
        nxt = cnt;
        if (up) begin
            if (cnt != CNT_MAX) begin
                nxt = cnt + 2'd1;
            end
        end else begin
            if (cnt != CNT_MIN) begin
                nxt = cnt - 2'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bpred_table.sv
// Table of 2-bit saturating-counter branch predictors.
//
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous, active-low; every counter returns to CNT_INIT
//   rd_idx  - lookup index (asynchronous read)
//   rd_cnt  - counter value at rd_idx
//   wr_en   - apply an update to the entry at wr_idx this cycle
//   wr_idx  - index of the entry being updated
//   wr_up   - 1 = branch taken (count up), 0 = not taken (count down)
//
// The read port has no bypass: a lookup on the entry being updated in the
// same cycle sees the value from before the update.

module bpred_table
    import branch_pkg::*;
#(
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_up
);

    localparam int DEPTH = 2 ** IDX_W;

    cnt_t cnt_q [DEPTH];

    assign rd_cnt = cnt_q[rd_idx];

    // Counter storage: cleared to CNT_INIT on reset, otherwise one entry
    // moves one saturating step per resolved branch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (wr_en) begin
            cnt_q[wr_idx] <= cnt_update(cnt_q[wr_idx], wr_up);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates MIPS conditional branches from raw
// register operands, registers the outcome, trains a PC-indexed table of
// 2-bit predictors and keeps saturating statistics.
//
// Ports:
//   clk, reset      - clock; asynchronous active-low reset
//   req_valid       - a resolve request is present this cycle
//   opcode          - instruction opcode field
//   op_a, op_b      - rs / rt operands (op_b used by beq/bne only)
//   req_pc          - PC of the branch being resolved
//   pred_taken_in   - prediction fetch used for this instruction
//   lookup_pc       - fetch PC to predict
//   lookup_taken    - combinational prediction for lookup_pc
//   res_valid       - one-cycle pulse, result fields valid
//   res_taken       - branch condition was true
//   res_is_branch   - opcode was one of the five branches
//   res_mispredict  - branch whose outcome differed from pred_taken_in
//   stat_branches   - resolved branch count, saturating
//   stat_mispred    - mispredict count, saturating
//
// Results have one cycle of latency; one request may be accepted per cycle.

module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int         DATA_W   = 32,
    parameter int         PC_W     = 32,
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         STAT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [5:0]        opcode,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [PC_W-1:0]   req_pc,
    input  logic              pred_taken_in,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              lookup_taken,
    output logic              res_valid,
    output logic              res_taken,
    output logic              res_is_branch,
    output logic              res_mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    logic             is_branch;
    logic             taken;
    logic             mispredict;
    logic             do_update;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] look_idx;
    logic [1:0]       look_cnt;

    // Instructions are word aligned, so the two low PC bits carry no
    // information and the index starts at bit 2
    assign upd_idx  = req_pc[IDX_W+1:2];
    assign look_idx = lookup_pc[IDX_W+1:2];

    // PC bits outside the index field are intentionally ignored
    logic unused_pc_bits;
    assign unused_pc_bits = ^{req_pc[PC_W-1:IDX_W+2], req_pc[1:0],
                              lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};

    // Condition decode; anything that is not one of the five branch
    // opcodes, including an undefined opcode, resolves as a non-branch
    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        case (opcode)
            OP_BEQ: begin
                is_branch = 1'b1;
                taken     = (op_a == op_b);
            end
            OP_BNE: begin
                is_branch = 1'b1;
                taken     = (op_a != op_b);
            end
            OP_BLEZ: begin
                is_branch = 1'b1;
                taken     = ($signed(op_a) <= $signed({DATA_W{1'b0}}));
            end
            OP_BGTZ: begin
                is_branch = 1'b1;
                taken     = ($signed(op_a) > $signed({DATA_W{1'b0}}));
            end
            OP_BLTZ: begin
                is_branch = 1'b1;
                taken     = ($signed(op_a) < $signed({DATA_W{1'b0}}));
            end
            default: begin
                is_branch = 1'b0;
                taken     = 1'b0;
            end
        endcase
    end

    assign mispredict = is_branch & (taken ^ pred_taken_in);
    assign do_update  = req_valid & is_branch;

    bpred_table #(
        .IDX_W    (IDX_W),
        .CNT_INIT (CNT_INIT)
    ) u_table (
        .clk    (clk),
        .reset  (reset),
        .rd_idx (look_idx),
        .rd_cnt (look_cnt),
        .wr_en  (do_update),
        .wr_idx (upd_idx),
        .wr_up  (taken)
    );

    assign lookup_taken = look_cnt[1];

    // Result registers: res_valid pulses for each accepted request while
    // the result fields hold their last values between requests. Reset
    // clears everything, which also drops a request in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid      <= 1'b0;
            res_taken      <= 1'b0;
            res_is_branch  <= 1'b0;
            res_mispredict <= 1'b0;
        end else begin
            res_valid <= req_valid;
            if (req_valid) begin
                res_taken      <= taken;
                res_is_branch  <= is_branch;
                res_mispredict <= mispredict;
            end
        end
    end

    // Statistics counters stick at all-ones rather than wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (do_update && (stat_branches != {STAT_W{1'b1}})) begin
                stat_branches <= stat_branches + {{(STAT_W-1){1'b0}}, 1'b1};
            end
            if (req_valid && mispredict && (stat_mispred != {STAT_W{1'b1}})) begin
                stat_mispred <= stat_mispred + {{(STAT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit. Requests are driven with
// their expected results pushed to a scoreboard queue; a monitor pops and
// compares each result when res_valid appears. A reference model tracks the
// predictor counters and statistics.

module tb_branch_resolve_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [5:0]  opcode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] req_pc;
    logic        pred_taken_in;
    logic [31:0] lookup_pc;
    logic        lookup_taken;
    logic        res_valid;
    logic        res_taken;
    logic        res_is_branch;
    logic        res_mispredict;
    logic [15:0] stat_branches;
    logic [15:0] stat_mispred;

    typedef struct packed {
        logic        taken;
        logic        is_branch;
        logic        mispred;
        logic [15:0] branches;
        logic [15:0] mispreds;
    } exp_t;

    exp_t        sb_q[$];
    logic [1:0]  mdl_cnt [16];
    logic [15:0] mdl_br;
    logic [15:0] mdl_mp;
    int          n_checks;
    int          n_fail;

    branch_resolve_unit dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .opcode         (opcode),
        .op_a           (op_a),
        .op_b           (op_b),
        .req_pc         (req_pc),
        .pred_taken_in  (pred_taken_in),
        .lookup_pc      (lookup_pc),
        .lookup_taken   (lookup_taken),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_is_branch  (res_is_branch),
        .res_mispredict (res_mispredict),
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference branch condition, written from the MIPS definitions
    function automatic void refDecode(input logic [5:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic isb, output logic tk);
        isb = 1'b1;
        tk  = 1'b0;
        case (op)
            6'd4:    tk = (a == b);
            6'd5:    tk = (a != b);
            6'd6:    tk = a[31] || (a == 32'd0);
            6'd7:    tk = !a[31] && (a != 32'd0);
            6'd1:    tk = a[31];
            default: isb = 1'b0;
        endcase
    endfunction

    function automatic void resetModel();
        for (int i = 0; i < 16; i++) mdl_cnt[i] = 2'b01;
        mdl_br = 16'd0;
        mdl_mp = 16'd0;
    endfunction

    // Drives one request for a single cycle, checks the pre-edge lookup
    // against the pre-update model, then updates the model and scoreboard
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic pred, input logic [31:0] lpc);
        logic isb, tk, mis;
        exp_t e;
        req_valid     = 1'b1;
        opcode        = op;
        op_a          = a;
        op_b          = b;
        req_pc        = pc;
        pred_taken_in = pred;
        lookup_pc     = lpc;
        refDecode(op, a, b, isb, tk);
        mis = isb && (tk != pred);
        #1;
        checkOutput("lookup_pre_edge", {31'd0, lookup_taken}, {31'd0, mdl_cnt[lpc[5:2]][1]});
        if (isb) begin
            if (tk && mdl_cnt[pc[5:2]] != 2'd3) mdl_cnt[pc[5:2]] = mdl_cnt[pc[5:2]] + 2'd1;
            if (!tk && mdl_cnt[pc[5:2]] != 2'd0) mdl_cnt[pc[5:2]] = mdl_cnt[pc[5:2]] - 2'd1;
            if (mdl_br != 16'hFFFF) mdl_br = mdl_br + 16'd1;
            if (mis && mdl_mp != 16'hFFFF) mdl_mp = mdl_mp + 16'd1;
        end
        e.taken     = isb && tk;
        e.is_branch = isb;
        e.mispred   = mis;
        e.branches  = mdl_br;
        e.mispreds  = mdl_mp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic checkLookup(input logic [31:0] pc, input logic [1:0] exp_cnt);
        lookup_pc = pc;
        #1;
        checkOutput("lookup_model", {31'd0, lookup_taken}, {31'd0, mdl_cnt[pc[5:2]][1]});
        checkOutput("counter_value", {30'd0, mdl_cnt[pc[5:2]]}, {30'd0, exp_cnt});
    endtask

    // Monitor: every res_valid must match the oldest outstanding request
    always begin
        @(posedge clk);
        #1;
        if (res_valid) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_res_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("res_taken", {31'd0, res_taken}, {31'd0, e.taken});
                checkOutput("res_is_branch", {31'd0, res_is_branch}, {31'd0, e.is_branch});
                checkOutput("res_mispredict", {31'd0, res_mispredict}, {31'd0, e.mispred});
                checkOutput("stat_branches", {16'd0, stat_branches}, {16'd0, e.branches});
                checkOutput("stat_mispred", {16'd0, stat_mispred}, {16'd0, e.mispreds});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        req_valid     = 1'b0;
        opcode        = 6'd0;
        op_a          = 32'd0;
        op_b          = 32'd0;
        req_pc        = 32'd0;
        pred_taken_in = 1'b0;
        lookup_pc     = 32'd0;
        resetModel();

        // Reset for three cycles, then check cleared state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("reset_res_taken", {31'd0, res_taken}, 32'd0);
        checkOutput("reset_res_is_branch", {31'd0, res_is_branch}, 32'd0);
        checkOutput("reset_res_mispredict", {31'd0, res_mispredict}, 32'd0);
        checkOutput("reset_stat_branches", {16'd0, stat_branches}, 32'd0);
        checkOutput("reset_stat_mispred", {16'd0, stat_mispred}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            lookup_pc = i << 2;
            #1;
            checkOutput("reset_lookup", {31'd0, lookup_taken}, 32'd0);
        end
        @(posedge clk);
        #1;

        // beq equal, predicted not-taken: taken + mispredict, idx4 -> 2
        applyStimulus(6'd4, 32'd5, 32'd5, 32'h10, 1'b0, 32'h10);
        checkLookup(32'h10, 2'd2);
        checkOutput("lookup_0x10_taken", {31'd0, lookup_taken}, 32'd1);

        // Signed boundaries, back to back
        applyStimulus(6'd6, 32'd0, 32'd0, 32'h40, 1'b1, 32'h40);
        applyStimulus(6'd7, 32'h8000_0000, 32'd0, 32'h44, 1'b1, 32'h44);
        applyStimulus(6'd1, 32'hFFFF_FFFF, 32'd0, 32'h48, 1'b0, 32'h48);
        applyStimulus(6'd5, 32'h1234, 32'h1234, 32'h4C, 1'b0, 32'h4C);
        applyStimulus(6'd7, 32'h7FFF_FFFF, 32'd0, 32'h4D, 1'b1, 32'h40);

        // Saturation at the top, then down to zero
        for (int i = 0; i < 4; i++) begin
            applyStimulus(6'd4, 32'd9, 32'd9, 32'h20, 1'b1, 32'h20);
        end
        checkLookup(32'h20, 2'd3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(6'd4, 32'd1, 32'd2, 32'h22, 1'b1, 32'h20);
        end
        checkLookup(32'h20, 2'd0);

        // Non-branch with prediction set; lookup on its index is unchanged
        applyStimulus(6'h23, 32'd3, 32'd3, 32'h10, 1'b1, 32'h10);
        checkLookup(32'h10, 2'd2);
        // Real collision: update and lookup on the same entry
        applyStimulus(6'd4, 32'd0, 32'd0, 32'h30, 1'b0, 32'h30);
        checkLookup(32'h30, 2'd2);

        // Statistics saturation
        @(posedge clk);
        #1;
        force dut.stat_branches = 16'hFFFE;
        #1;
        release dut.stat_branches;
        mdl_br = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(6'd5, i, 32'd7, 32'h50 + (i << 2), 1'b0, 32'h0);
        end
        @(posedge clk);
        #1;
        checkOutput("stat_branches_hold", {16'd0, stat_branches}, 32'h0000_FFFF);
        checkOutput("res_valid_idle", {31'd0, res_valid}, 32'd0);

        // Reset with a request in flight: it must be dropped
        req_valid     = 1'b1;
        opcode        = 6'd4;
        op_a          = 32'd1;
        op_b          = 32'd1;
        req_pc        = 32'h10;
        pred_taken_in = 1'b0;
        #2;
        reset = 1'b0;
        resetModel();
        @(posedge clk);
        #1;
        checkOutput("inreset_res_valid", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("post_reset_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("post_reset_res_taken", {31'd0, res_taken}, 32'd0);
        checkOutput("post_reset_stat_branches", {16'd0, stat_branches}, 32'd0);
        checkOutput("post_reset_stat_mispred", {16'd0, stat_mispred}, 32'd0);
        checkLookup(32'h10, 2'd1);
        checkOutput("post_reset_lookup", {31'd0, lookup_taken}, 32'd0);

        checkOutput("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
